// File: rtl/sub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sub_arbiter
//  Purpose  : Round-robin arbiter that time-shares one combinational
//             subtractor (X = A - B) among N_REQ requesters. It accepts one
//             operand pair, drives the shared subtractor from registers,
//             captures the result and returns it tagged with the owner's ID.
//  Revision : 1.0 - initial release
// ============================================================================
module sub_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int N_REQ      = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    // requester side
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    // shared subtractor
    output logic [DATA_WIDTH-1:0]       sub_a,
    output logic [DATA_WIDTH-1:0]       sub_b,
    input  logic [DATA_WIDTH:0]         sub_x,
    // response side
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic [DATA_WIDTH:0]         resp_x
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_RESP  = 2'd2;

    // Pointer value after reset: the last requester, so requester 0 wins first
    localparam logic [ID_W-1:0] C_PTR_RST = ID_W'(N_REQ - 1);

    logic [1:0]            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH:0]   resp_x_q, resp_x_d;
    logic [ID_W-1:0]       resp_id_q, resp_id_d;

    logic                  grant_any;
    logic [ID_W-1:0]       grant_idx;
    logic [N_REQ-1:0]      grant_onehot;
    logic                  accept;

    logic [DATA_WIDTH-1:0] req_a_arr [N_REQ];
    logic [DATA_WIDTH-1:0] req_b_arr [N_REQ];

    // ------------------------------------------------------------------------
    // Unpack the flat operand buses into per-requester slices and build the
    // one-hot form of the selected grant index.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_a_arr[gi]    = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_b_arr[gi]    = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign grant_onehot[gi] = grant_any && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester starting at ptr+1, wrapping.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // State register with synchronous reset; reset discards any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // IDLE -> ISSUE on any grant, ISSUE -> RESP unconditionally,
    // RESP -> IDLE once the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (grant_any) begin
                    state_d = C_ST_ISSUE;
                end
            end
            C_ST_ISSUE: begin
                state_d = C_ST_RESP;
            end
            C_ST_RESP: begin
                if (resp_ready) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // req_ready is only offered in IDLE and is forced low while in reset so a
    // requester never believes it was accepted on a reset edge.
    always_comb begin
        accept     = (state_q == C_ST_IDLE) && grant_any;
        req_ready  = '0;
        resp_valid = (state_q == C_ST_RESP);
        if (accept && !rst) begin
            req_ready = grant_onehot;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, result capture, round-robin pointer
    // ------------------------------------------------------------------------
    // Operands and owner ID are captured on acceptance; the subtractor result
    // is captured at the end of ISSUE when the operands have been stable for a
    // full cycle.
    always_comb begin
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        resp_x_d  = resp_x_q;
        resp_id_d = resp_id_q;
        ptr_d     = ptr_q;
        if (accept) begin
            op_a_d    = req_a_arr[grant_idx];
            op_b_d    = req_b_arr[grant_idx];
            resp_id_d = grant_idx;
            ptr_d     = grant_idx;
        end
        if (state_q == C_ST_ISSUE) begin
            resp_x_d = sub_x;
        end
    end

    // Datapath registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            resp_x_q  <= '0;
            resp_id_q <= '0;
            ptr_q     <= C_PTR_RST;
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            resp_x_q  <= resp_x_d;
            resp_id_q <= resp_id_d;
            ptr_q     <= ptr_d;
        end
    end

    // The shared subtractor always sees the registered operands.
    assign sub_a   = op_a_q;
    assign sub_b   = op_b_q;
    assign resp_x  = resp_x_q;
    assign resp_id = resp_id_q;

endmodule
`default_nettype wire
